multi_issue_launch: RTL

MULTI_ISSUE_LAUNCH -- requirements
Module: multi_issue_launch

---
 rtl/multi_issue_launch_pkg.sv | 26 ++
 rtl/launch_raw_check.sv | 27 ++
 rtl/multi_issue_launch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multi_issue_launch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_issue_launch_pkg : shared defaults and per-entry field layout   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package multi_issue_launch_pkg;

    localparam int WAYS_DEF  = 2;
    localparam int DEPTH_DEF = 4;
    localparam int PAY_W_DEF = 64;
    localparam int REG_AW    = 5;

    // Entry layout: these control fields, followed by the PAY_W-bit payload
    // which lives in its own array so its width can follow the parameter.
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic              re1;
        logic [REG_AW-1:0] raddr1;
        logic              re2;
        logic [REG_AW-1:0] raddr2;
        logic              pair_ok;
    } launch_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/launch_raw_check.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | launch_raw_check : read-after-write hazard between an earlier and a   |
// | later slot of the same issue group.  Rev 1.0                          |
// +-----------------------------------------------------------------------+
module launch_raw_check
    import multi_issue_launch_pkg::*;
(
    input  logic              early_we_i,
    input  logic [REG_AW-1:0] early_waddr_i,
    input  logic              late_re1_i,
    input  logic [REG_AW-1:0] late_raddr1_i,
    input  logic              late_re2_i,
    input  logic [REG_AW-1:0] late_raddr2_i,
    output logic              raw_o
);

    logic w_writes;

    // r0 is hardwired zero, so a write to it never creates a dependency.
    assign w_writes = early_we_i && (early_waddr_i != '0);
    assign raw_o    = w_writes &&
                      ((late_re1_i && (late_raddr1_i == early_waddr_i)) ||
                       (late_re2_i && (late_raddr2_i == early_waddr_i)));

endmodule
`default_nettype wire

// File: rtl/multi_issue_launch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_issue_launch : circular issue buffer launching up to WAYS       |
// | in-order instructions per cycle.  Rev 1.0                             |
// +-----------------------------------------------------------------------+
module multi_issue_launch
    import multi_issue_launch_pkg::*;
#(
    parameter int WAYS  = WAYS_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PAY_W = PAY_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WAYS-1:0]           in_valid_i,
    input  logic [WAYS*PAY_W-1:0]     in_payload_i,
    input  logic [WAYS-1:0]           in_we_i,
    input  logic [WAYS-1:0]           in_re1_i,
    input  logic [WAYS-1:0]           in_re2_i,
    input  logic [WAYS-1:0]           in_pair_ok_i,
    input  logic [WAYS*REG_AW-1:0]    in_waddr_i,
    input  logic [WAYS*REG_AW-1:0]    in_raddr1_i,
    input  logic [WAYS*REG_AW-1:0]    in_raddr2_i,
    output logic                      now_allowin_o,
    input  logic                      excep_flush_i,
    input  logic                      single_mode_i,
    input  logic                      next_allowin_i,
    output logic [WAYS-1:0]           out_valid_o,
    output logic [WAYS*PAY_W-1:0]     out_payload_o,
    output logic [$clog2(WAYS+1)-1:0] out_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int K_W   = $clog2(WAYS+1);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    launch_ctrl_t     ctrl_q [DEPTH];
    launch_ctrl_t     ctrl_d [DEPTH];
    logic [PAY_W-1:0] pay_q  [DEPTH];
    logic [PAY_W-1:0] pay_d  [DEPTH];

    logic [K_W-1:0]   w_enq_n, w_iss_n;
    logic             w_run_enq, w_run_iss;
    launch_ctrl_t     w_head_ctrl [WAYS];
    logic [WAYS-1:0]  w_head_vld;
    logic [WAYS-1:0]  w_raw [WAYS];
    logic             w_unused;

    assign now_allowin_o = (count_q <= CNT_W'(DEPTH - WAYS));

    generate
        for (genvar j = 0; j < WAYS; j++) begin : g_head
            logic [PTR_W-1:0] w_idx;
            assign w_idx          = head_q + PTR_W'(j);
            assign w_head_ctrl[j] = ctrl_q[w_idx];
            assign w_head_vld[j]  = (count_q > CNT_W'(j));
            assign out_payload_o[j*PAY_W +: PAY_W] = pay_q[w_idx];
            for (genvar i = 0; i < WAYS; i++) begin : g_pair
                if (i < j) begin : g_cmp
                    launch_raw_check u_raw (
                        .early_we_i    (w_head_ctrl[i].we),
                        .early_waddr_i (w_head_ctrl[i].waddr),
                        .late_re1_i    (w_head_ctrl[j].re1),
                        .late_raddr1_i (w_head_ctrl[j].raddr1),
                        .late_re2_i    (w_head_ctrl[j].re2),
                        .late_raddr2_i (w_head_ctrl[j].raddr2),
                        .raw_o         (w_raw[j][i])
                    );
                end else begin : g_none
                    assign w_raw[j][i] = 1'b0;
                end
            end
        end
    endgenerate

    // Slot 0 is never a consumer and the last slot never a producer.
    assign w_unused = ^{w_head_ctrl[0], w_head_ctrl[WAYS-1]};

    // Issue count: longest prefix of head entries that may launch together.
    always_comb begin
        w_iss_n   = '0;
        w_run_iss = next_allowin_i & ~excep_flush_i;
        for (int j = 0; j < WAYS; j++) begin
            w_run_iss = w_run_iss & w_head_vld[j];
            if (j > 0) begin
                w_run_iss = w_run_iss & w_head_ctrl[j].pair_ok &
                            ~single_mode_i & ~(|w_raw[j]);
            end
            if (w_run_iss) begin
                w_iss_n = K_W'(j + 1);
            end
        end
    end

    always_comb begin
        w_enq_n   = '0;
        w_run_enq = now_allowin_o & ~excep_flush_i;
        for (int l = 0; l < WAYS; l++) begin
            w_run_enq = w_run_enq & in_valid_i[l];
            if (w_run_enq) begin
                w_enq_n = K_W'(l + 1);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            out_valid_o[j] = (K_W'(j) < w_iss_n);
        end
        out_count_o = w_iss_n;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        pay_d  = pay_q;
        for (int l = 0; l < WAYS; l++) begin
            if (K_W'(l) < w_enq_n) begin
                ctrl_d[tail_q + PTR_W'(l)] = '{
                    we:      in_we_i[l],
                    waddr:   in_waddr_i[l*REG_AW +: REG_AW],
                    re1:     in_re1_i[l],
                    raddr1:  in_raddr1_i[l*REG_AW +: REG_AW],
                    re2:     in_re2_i[l],
                    raddr2:  in_raddr2_i[l*REG_AW +: REG_AW],
                    pair_ok: in_pair_ok_i[l]
                };
                pay_d[tail_q + PTR_W'(l)] = in_payload_i[l*PAY_W +: PAY_W];
            end
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(w_iss_n);
        tail_d  = tail_q + PTR_W'(w_enq_n);
        count_d = count_q + CNT_W'(w_enq_n) - CNT_W'(w_iss_n);
        if (excep_flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; validity comes from the count alone.
    always_ff @(posedge clk) begin
        ctrl_q <= ctrl_d;
        pay_q  <= pay_d;
    end

endmodule
`default_nettype wire
